fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_pkg.sv | 28 ++
 rtl/fwd_match.sv | 37 +++
 rtl/fwd_hazard_unit.sv | 138 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared types and constants for the forwarding/hazard unit
//   sb_entry_t : one scoreboard entry {valid, rd, is_load}
//   *_LSB      : bit positions of the register fields in the instruction word
//   FWD_NONE   : forward-select value meaning "use the register file"
package fwd_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    localparam int RD_LSB   = 7;
    localparam int RS1_LSB  = 15;
    localparam int RS2_LSB  = 20;
    localparam int RS3_LSB  = 27;
    localparam int FWD_NONE = 0;

    // Instruction-word LSB of source operand number idx (0 = rs1, 1 = rs2, 2 = rs3).
    function automatic int src_lsb(input int idx);
        case (idx)
            0:       return RS1_LSB;
            1:       return RS2_LSB;
            default: return RS3_LSB;
        endcase
    endfunction

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - per-source scoreboard comparator and youngest-first priority encoder
//   src_used : operand is actually read by the EX instruction
//   src_reg  : source register number
//   entries  : scoreboard, index 0 = MEM (youngest producer)
//   hit      : some valid, non-x0 entry writes src_reg
//   index    : stage index of the youngest matching entry
//   is_load  : that entry is a load
module fwd_match
    import fwd_pkg::*;
#(
    parameter int FWD_DEPTH = 2,
    parameter int IDXW      = 2
) (
    input  logic                        src_used,
    input  logic [4:0]                  src_reg,
    input  sb_entry_t [FWD_DEPTH-1:0]   entries,
    output logic                        hit,
    output logic [IDXW-1:0]             index,
    output logic                        is_load
);

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        hit     = 1'b0;
        index   = '0;
        is_load = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (src_used && entries[k].valid && (entries[k].rd != 5'd0) &&
                (entries[k].rd == src_reg)) begin
                hit     = 1'b1;
                index   = IDXW'(k);
                is_load = entries[k].is_load;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX-stage operand forwarding select and load-use stall generation
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_ex_valid/inst       : EX instruction and its word (rd, rs1, rs2, rs3 fields)
//   i_ex_src_used         : per-source "operand is read" mask
//   i_ex_rd_wren/is_load  : EX instruction writes rd / is a load
//   i_flush, i_hold       : kill EX instruction / freeze back-end
//   o_fwd_sel             : per-source select, 0 = none, k = forward from stage k-1
//   o_stall               : load-use stall request
//   o_stall_cnt/o_fwd_cnt : event counters, present only with FWD_HAZARD_STATS_EN
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int  NUM_SRC          = 2,
    parameter int  FWD_DEPTH        = 2,
    parameter int  LOAD_READY_STAGE = 1,
    localparam int SELW             = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_ex_valid,
    input  logic [31:0]                   i_ex_inst,
    input  logic [NUM_SRC-1:0]            i_ex_src_used,
    input  logic                          i_ex_rd_wren,
    input  logic                          i_ex_is_load,
    input  logic                          i_flush,
    input  logic                          i_hold,
    output logic [NUM_SRC-1:0][SELW-1:0]  o_fwd_sel,
    output logic                          o_stall
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]                   o_stall_cnt,
    output logic [31:0]                   o_fwd_cnt
`endif
);

    if (NUM_SRC < 2 || NUM_SRC > 3) begin : g_bad_num_src
        $error("fwd_hazard_unit: NUM_SRC must be 2 or 3");
    end
    if (FWD_DEPTH < 1 || FWD_DEPTH > 6) begin : g_bad_depth
        $error("fwd_hazard_unit: FWD_DEPTH must be 1..6");
    end
    if (LOAD_READY_STAGE < 0 || LOAD_READY_STAGE > FWD_DEPTH - 1) begin : g_bad_ready
        $error("fwd_hazard_unit: LOAD_READY_STAGE must be 0..FWD_DEPTH-1");
    end

    sb_entry_t [FWD_DEPTH-1:0]   sb_q;
    sb_entry_t                   new_entry;
    logic [NUM_SRC-1:0]          src_hit;
    logic [NUM_SRC-1:0]          src_load;
    logic [NUM_SRC-1:0][SELW-1:0] src_idx;
    logic                        stall_cond;
    logic                        capture;

    // Opcode/funct bits never participate in hazard detection.
    logic unused_inst;
    assign unused_inst = ^{i_ex_inst[31:25], i_ex_inst[14:12], i_ex_inst[6:0]};

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        localparam int LSB = src_lsb(s);
        fwd_match #(
            .FWD_DEPTH (FWD_DEPTH),
            .IDXW      (SELW)
        ) u_match (
            .src_used (i_ex_src_used[s]),
            .src_reg  (i_ex_inst[LSB +: 5]),
            .entries  (sb_q),
            .hit      (src_hit[s]),
            .index    (src_idx[s]),
            .is_load  (src_load[s])
        );
    end

    // A load whose winning stage is still younger than the ready stage cannot be forwarded yet.
    always_comb begin
        stall_cond = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (src_hit[s] && src_load[s] && (int'(src_idx[s]) < LOAD_READY_STAGE)) begin
                stall_cond = 1'b1;
            end
        end
    end

    assign o_stall = i_ex_valid & ~i_flush & stall_cond;

    always_comb begin
        o_fwd_sel = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (i_ex_valid && !o_stall && src_hit[s]) begin
                o_fwd_sel[s] = src_idx[s] + SELW'(1);
            end else begin
                o_fwd_sel[s] = SELW'(FWD_NONE);
            end
        end
    end

    // A stalled or flushed instruction enters the scoreboard as a bubble.
    assign capture = i_ex_valid & i_ex_rd_wren & ~o_stall & ~i_flush;

    always_comb begin
        new_entry = '0;
        if (capture) begin
            new_entry.valid   = 1'b1;
            new_entry.rd      = i_ex_inst[RD_LSB +: 5];
            new_entry.is_load = i_ex_is_load;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sb_q <= '0;
        end else if (!i_hold) begin
            for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
                sb_q[k] <= sb_q[k-1];
            end
            sb_q[0] <= new_entry;
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic any_fwd;
    assign any_fwd = |o_fwd_sel;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
            o_fwd_cnt   <= '0;
        end else if (!i_hold) begin
            if (o_stall) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
            if (any_fwd) begin
                o_fwd_cnt <= o_fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

    localparam int NUM_SRC   = 2;
    localparam int FWD_DEPTH = 2;
    localparam int LRS       = 1;
    localparam int SELW      = 2;

    logic                          i_clk = 1'b0;
    logic                          i_rst_n;
    logic                          i_ex_valid;
    logic [31:0]                   i_ex_inst;
    logic [NUM_SRC-1:0]            i_ex_src_used;
    logic                          i_ex_rd_wren;
    logic                          i_ex_is_load;
    logic                          i_flush;
    logic                          i_hold;
    logic [NUM_SRC-1:0][SELW-1:0]  o_fwd_sel;
    logic                          o_stall;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0]                   o_stall_cnt;
    logic [31:0]                   o_fwd_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference scoreboard: index 0 = MEM.
    int m_v  [FWD_DEPTH];
    int m_rd [FWD_DEPTH];
    int m_ld [FWD_DEPTH];

    always #5 i_clk = ~i_clk;

    fwd_hazard_unit #(
        .NUM_SRC          (NUM_SRC),
        .FWD_DEPTH        (FWD_DEPTH),
        .LOAD_READY_STAGE (LRS)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_ex_valid    (i_ex_valid),
        .i_ex_inst     (i_ex_inst),
        .i_ex_src_used (i_ex_src_used),
        .i_ex_rd_wren  (i_ex_rd_wren),
        .i_ex_is_load  (i_ex_is_load),
        .i_flush       (i_flush),
        .i_hold        (i_hold),
        .o_fwd_sel     (o_fwd_sel),
        .o_stall       (o_stall)
`ifdef FWD_HAZARD_STATS_EN
        ,
        .o_stall_cnt   (o_stall_cnt),
        .o_fwd_cnt     (o_fwd_cnt)
`endif
    );

    function automatic logic [31:0] mk_inst(input int rd, input int rs1, input int rs2, input int rs3);
        logic [31:0] w;
        w        = '0;
        w[6:0]   = 7'h33;
        w[11:7]  = rd[4:0];
        w[19:15] = rs1[4:0];
        w[24:20] = rs2[4:0];
        w[31:27] = rs3[4:0];
        return w;
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [NUM_SRC-1:0] used,
                         input logic wren, input logic ld, input logic fl, input logic hd);
        i_ex_valid    = v;
        i_ex_inst     = inst;
        i_ex_src_used = used;
        i_ex_rd_wren  = wren;
        i_ex_is_load  = ld;
        i_flush       = fl;
        i_hold        = hd;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        next_cycle();
        i_rst_n = 1'b1;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            m_v[k] = 0; m_rd[k] = 0; m_ld[k] = 0;
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        drive(1'b1, mk_inst(0, 5, 6, 0), 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        n_tests++;
        if (o_stall !== 1'b0 || o_fwd_sel !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: stall=%0b sel=%h expected stall=0 sel=0", o_stall, o_fwd_sel);
        end
        next_cycle();
        i_rst_n = 1'b1;
        drive(1'b1, mk_inst(0, 5, 6, 0), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        n_tests++;
        if (o_stall !== 1'b0 || o_fwd_sel !== '0) begin
            n_fail++;
            $display("FAIL reset_empty_sb: stall=%0b sel=%h expected stall=0 sel=0", o_stall, o_fwd_sel);
        end
`ifdef FWD_HAZARD_STATS_EN
        n_tests++;
        if (o_stall_cnt !== 32'd0 || o_fwd_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters: stall_cnt=%0d fwd_cnt=%0d expected 0 0", o_stall_cnt, o_fwd_cnt);
        end
`endif
        next_cycle();
    endtask

    task automatic test_alu_producer();
        do_reset();
        drive(1'b1, mk_inst(5, 1, 2, 0), 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, mk_inst(0, 5, 9, 0), 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        n_tests++;
        if (o_fwd_sel[0] !== 2'd1 || o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_sel_mem: sel0=%0d stall=%0b expected sel0=1 stall=0", o_fwd_sel[0], o_stall);
        end
        next_cycle();
        @(negedge i_clk);
        n_tests++;
        if (o_fwd_sel[0] !== 2'd2) begin
            n_fail++;
            $display("FAIL alu_sel_wb: sel0=%0d expected 2", o_fwd_sel[0]);
        end
        next_cycle();
        @(negedge i_clk);
        n_tests++;
        if (o_fwd_sel[0] !== 2'd0) begin
            n_fail++;
            $display("FAIL alu_sel_gone: sel0=%0d expected 0", o_fwd_sel[0]);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, mk_inst(7, 2, 0, 0), 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, mk_inst(0, 1, 7, 0), 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        n_tests++;
        if (o_stall !== 1'b1 || o_fwd_sel !== '0) begin
            n_fail++;
            $display("FAIL load_use_stall: stall=%0b sel=%h expected stall=1 sel=0", o_stall, o_fwd_sel);
        end
        next_cycle();
        @(negedge i_clk);
        n_tests++;
        if (o_stall !== 1'b0 || o_fwd_sel[1] !== 2'd2) begin
            n_fail++;
            $display("FAIL load_use_fwd: stall=%0b sel1=%0d expected stall=0 sel1=2", o_stall, o_fwd_sel[1]);
        end
        next_cycle();
    endtask

    task automatic test_youngest_wins();
        do_reset();
        drive(1'b1, mk_inst(3, 0, 0, 0), 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, mk_inst(3, 0, 0, 0), 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, mk_inst(0, 3, 3, 0), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        n_tests++;
        if (o_fwd_sel[0] !== 2'd1 || o_fwd_sel[1] !== 2'd1) begin
            n_fail++;
            $display("FAIL youngest_wins: sel0=%0d sel1=%0d expected 1 1", o_fwd_sel[0], o_fwd_sel[1]);
        end
        next_cycle();
    endtask

    task automatic test_x0_unused();
        do_reset();
        drive(1'b1, mk_inst(0, 0, 0, 0), 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, mk_inst(0, 0, 0, 0), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        n_tests++;
        if (o_stall !== 1'b0 || o_fwd_sel !== '0) begin
            n_fail++;
            $display("FAIL x0_producer: stall=%0b sel=%h expected stall=0 sel=0", o_stall, o_fwd_sel);
        end
        next_cycle();
        drive(1'b1, mk_inst(9, 0, 0, 0), 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, mk_inst(0, 9, 9, 0), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        n_tests++;
        if (o_stall !== 1'b0 || o_fwd_sel !== '0) begin
            n_fail++;
            $display("FAIL unused_src: stall=%0b sel=%h expected stall=0 sel=0", o_stall, o_fwd_sel);
        end
        i_ex_src_used = 2'b01;
        #1;
        n_tests++;
        if (o_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL used_src_stall: stall=%0b expected 1", o_stall);
        end
        next_cycle();
    endtask

    task automatic test_hold_flush();
        do_reset();
        drive(1'b1, mk_inst(7, 0, 0, 0), 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, mk_inst(7, 7, 0, 0), 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        n_tests++;
        if (o_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_pre_stall: stall=%0b expected 1", o_stall);
        end
        i_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge i_clk);
            n_tests++;
            if (o_stall !== 1'b1 || o_fwd_sel !== '0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: stall=%0b sel=%h expected stall=1 sel=0", c, o_stall, o_fwd_sel);
            end
        end
        i_hold  = 1'b0;
        i_flush = 1'b1;
        #1;
        n_tests++;
        if (o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall: stall=%0b expected 0", o_stall);
        end
        next_cycle();
        drive(1'b1, mk_inst(0, 7, 0, 0), 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        n_tests++;
        if (o_fwd_sel[0] !== 2'd2 || o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_bubble: sel0=%0d stall=%0b expected sel0=2 stall=0", o_fwd_sel[0], o_stall);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b1, mk_inst(7, 0, 0, 0), 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, mk_inst(0, 0, 7, 0), 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        n_tests++;
        if (o_stall !== 1'b0 || o_fwd_sel !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: stall=%0b sel=%h expected stall=0 sel=0", o_stall, o_fwd_sel);
        end
`ifdef FWD_HAZARD_STATS_EN
        n_tests++;
        if (o_stall_cnt !== 32'd0 || o_fwd_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_counters: stall_cnt=%0d fwd_cnt=%0d expected 0 0", o_stall_cnt, o_fwd_cnt);
        end
`endif
        next_cycle();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        n_tests++;
        if (o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_stall: stall=%0b expected 0", o_stall);
        end
        next_cycle();
        drive(1'b1, mk_inst(7, 0, 0, 0), 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, mk_inst(0, 0, 7, 0), 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        n_tests++;
        if (o_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_load_use: stall=%0b expected 1", o_stall);
        end
        next_cycle();
`ifdef FWD_HAZARD_STATS_EN
        n_tests++;
        if (o_stall_cnt !== 32'd1 || o_fwd_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL stall_count_one: stall_cnt=%0d fwd_cnt=%0d expected 1 0", o_stall_cnt, o_fwd_cnt);
        end
`endif
    endtask

    task automatic test_random();
        int exp_scnt;
        int exp_fcnt;
        do_reset();
        exp_scnt = 0;
        exp_fcnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int v, rd, rs1, rs2, used, wren, ld, fl, hd;
            int win [NUM_SRC];
            int exp_sel [NUM_SRC];
            int exp_stall;
            int any_sel;
            v    = ($urandom_range(0, 9) != 0) ? 1 : 0;
            rd   = $urandom_range(0, 3);
            rs1  = $urandom_range(0, 3);
            rs2  = $urandom_range(0, 3);
            used = $urandom_range(0, 3);
            wren = $urandom_range(0, 3) != 0 ? 1 : 0;
            ld   = $urandom_range(0, 2) == 0 ? 1 : 0;
            fl   = $urandom_range(0, 9) == 0 ? 1 : 0;
            hd   = $urandom_range(0, 7) == 0 ? 1 : 0;
            drive(v[0], mk_inst(rd, rs1, rs2, $urandom_range(0, 31)), used[1:0], wren[0], ld[0], fl[0], hd[0]);
            @(negedge i_clk);

            exp_stall = 0;
            for (int s = 0; s < NUM_SRC; s++) begin
                int field;
                field  = (s == 0) ? rs1 : rs2;
                win[s] = -1;
                if (used[s]) begin
                    for (int k = 0; k < FWD_DEPTH; k++) begin
                        if (win[s] < 0 && m_v[k] != 0 && m_rd[k] != 0 && m_rd[k] == field) win[s] = k;
                    end
                end
                if (win[s] >= 0 && m_ld[win[s]] != 0 && win[s] < LRS) exp_stall = 1;
            end
            if (v == 0 || fl != 0) exp_stall = 0;
            any_sel = 0;
            for (int s = 0; s < NUM_SRC; s++) begin
                exp_sel[s] = (v != 0 && exp_stall == 0 && win[s] >= 0) ? win[s] + 1 : 0;
                if (exp_sel[s] != 0) any_sel = 1;
            end

            n_tests++;
            if (o_stall !== exp_stall[0]) begin
                n_fail++;
                $display("FAIL rand_stall cyc=%0d: got %0b expected %0d", cyc, o_stall, exp_stall);
            end
            for (int s = 0; s < NUM_SRC; s++) begin
                n_tests++;
                if (o_fwd_sel[s] !== 2'(exp_sel[s])) begin
                    n_fail++;
                    $display("FAIL rand_sel%0d cyc=%0d: got %0d expected %0d", s, cyc, o_fwd_sel[s], exp_sel[s]);
                end
            end

            if (hd == 0) begin
                for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
                    m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
                end
                if (v != 0 && wren != 0 && exp_stall == 0 && fl == 0) begin
                    m_v[0] = 1; m_rd[0] = rd; m_ld[0] = ld;
                end else begin
                    m_v[0] = 0; m_rd[0] = 0; m_ld[0] = 0;
                end
                exp_scnt += exp_stall;
                exp_fcnt += any_sel;
            end
            next_cycle();
        end
`ifdef FWD_HAZARD_STATS_EN
        n_tests++;
        if (o_stall_cnt !== 32'(exp_scnt) || o_fwd_cnt !== 32'(exp_fcnt)) begin
            n_fail++;
            $display("FAIL rand_counters: stall_cnt=%0d fwd_cnt=%0d expected %0d %0d",
                     o_stall_cnt, o_fwd_cnt, exp_scnt, exp_fcnt);
        end
`endif
    endtask

    initial begin
        i_rst_n = 1'b0;
        drive(1'b0, 32'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        test_reset();
        test_alu_producer();
        test_load_use();
        test_youngest_wins();
        test_x0_unused();
        test_hold_flush();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
